// File: rtl/fft_wb_frame_ctrl_if.sv
// Wishbone classic slave bus bundle used by the FFT frame controller.
// master drives the cycle; slave returns data with a single ACK or ERR pulse.
interface fft_wb_frame_ctrl_if #(
    parameter int WB_Width         = 32,
    parameter int Adress_wordwidth = 32
);
    logic                        CYC_I;
    logic                        STB_I;
    logic                        WE_I;
    logic [Adress_wordwidth-1:0] ADR_I;
    logic [WB_Width-1:0]         DAT_I;
    logic [WB_Width-1:0]         DAT_O;
    logic                        ACK_O;
    logic                        ERR_O;

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        output DAT_O, ACK_O, ERR_O
    );

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        input  DAT_O, ACK_O, ERR_O
    );
endinterface

// File: rtl/fft_wb_frame_ctrl.sv
// Wishbone front-end for a streaming FFT core: buffers one N-sample frame, streams it
// into the core, captures the output bins and reports DONE/IRQ, frame count and bus errors.
module fft_wb_frame_ctrl #(
    parameter int WB_Width         = 32,
    parameter int Adress_wordwidth = 32,
    parameter int N                = 1024,
    parameter int Log2N            = 10,
    parameter int reg_control      = 0,
    parameter int reg_data         = 4,
    parameter int reg_status       = 8,
    parameter int reg_memory       = 12
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    fft_wb_frame_ctrl_if.slave   wb,
    output logic                 IRQ_O,
    output logic                 core_enable,
    output logic                 core_clear,
    output logic                 core_inverse,
    output logic [WB_Width-1:0]  core_xin,
    input  logic                 core_out_valid,
    input  logic [Log2N-1:0]     core_index,
    input  logic [WB_Width-1:0]  core_xout,
    input  logic                 core_frame_ready,
    output logic [1:0]           dbg_state
);
    localparam int AW = Adress_wordwidth;
    localparam int PW = Log2N + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [Log2N-1:0]     rd_cnt_q, rd_cnt_d;
    logic                 done_q, done_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 inv_q, inv_d;
    logic                 irq_en_q, irq_en_d;
    logic                 core_inv_q, core_inv_d;
    logic                 core_en_q, core_en_d;
    logic                 core_clear_q, core_clear_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [WB_Width-1:0]  dat_q, dat_d;
    logic                 mem_sel_q, mem_sel_d;

    logic [WB_Width-1:0]  inbuf_mem  [N];
    logic [WB_Width-1:0]  outbuf_mem [N];
    logic [WB_Width-1:0]  inbuf_rd_q;
    logic [WB_Width-1:0]  mem_rd_q;

    logic                 access, busy, in_full;
    logic                 sel_ctrl, sel_data, sel_status, sel_mem;
    logic [AW-1:0]        mem_off;
    logic [Log2N-1:0]     mem_idx;
    logic                 in_we, mem_rd_en, start_cmd, abort_cmd, ctrl_wr, w1c;
    logic                 frame_done;
    logic [WB_Width-1:0]  status_word, ctrl_word;

    assign access  = wb.CYC_I & wb.STB_I & ~ack_q & ~err_q;
    assign busy    = (state_q == S_RUN) || (state_q == S_WAIT);
    assign in_full = (wr_ptr_q == PW'(N));

    assign sel_ctrl   = (wb.ADR_I == AW'(reg_control));
    assign sel_data   = (wb.ADR_I == AW'(reg_data));
    assign sel_status = (wb.ADR_I == AW'(reg_status));
    assign mem_off    = wb.ADR_I - AW'(reg_memory);
    assign sel_mem    = (wb.ADR_I >= AW'(reg_memory)) && (mem_off < AW'(4 * N))
                        && (mem_off[1:0] == 2'b00);
    assign mem_idx    = mem_off[Log2N+1:2];

    always_comb begin
        status_word                        = '0;
        status_word[0]                     = busy;
        status_word[1]                     = done_q;
        status_word[2]                     = in_full;
        status_word[WB_Width-1:WB_Width-16] = frame_cnt_q;
        ctrl_word    = '0;
        ctrl_word[1] = inv_q;
        ctrl_word[2] = irq_en_q;
    end

    // Bus decode: every access gets exactly one ACK or ERR on the following cycle.
    always_comb begin
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = '0;
        mem_sel_d = 1'b0;
        in_we     = 1'b0;
        mem_rd_en = 1'b0;
        start_cmd = 1'b0;
        abort_cmd = 1'b0;
        ctrl_wr   = 1'b0;
        w1c       = 1'b0;
        if (access) begin
            if (sel_ctrl) begin
                if (wb.WE_I) begin
                    if (wb.DAT_I[3]) begin
                        abort_cmd = 1'b1;
                        ctrl_wr   = 1'b1;
                        ack_d     = 1'b1;
                    end else if (wb.DAT_I[0]) begin
                        if ((state_q == S_LOAD) && in_full) begin
                            start_cmd = 1'b1;
                            ctrl_wr   = 1'b1;
                            ack_d     = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        ctrl_wr = 1'b1;
                        ack_d   = 1'b1;
                    end
                end else begin
                    dat_d = ctrl_word;
                    ack_d = 1'b1;
                end
            end else if (sel_data) begin
                if (wb.WE_I) begin
                    if (((state_q == S_IDLE) || (state_q == S_LOAD)) && !in_full) begin
                        in_we = 1'b1;
                        ack_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    dat_d = WB_Width'(wr_ptr_q);
                    ack_d = 1'b1;
                end
            end else if (sel_status) begin
                if (wb.WE_I) begin
                    w1c = wb.DAT_I[1];
                end else begin
                    dat_d = status_word;
                end
                ack_d = 1'b1;
            end else if (sel_mem) begin
                if (wb.WE_I || busy) begin
                    err_d = 1'b1;
                end else begin
                    mem_rd_en = 1'b1;
                    mem_sel_d = 1'b1;
                    ack_d     = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Frame FSM; abort is applied last so it overrides everything else in its cycle.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        done_d       = done_q;
        frame_cnt_d  = frame_cnt_q;
        inv_d        = inv_q;
        irq_en_d     = irq_en_q;
        core_inv_d   = core_inv_q;
        core_en_d    = 1'b0;
        core_clear_d = 1'b0;
        frame_done   = 1'b0;

        if (ctrl_wr) begin
            inv_d    = wb.DAT_I[1];
            irq_en_d = wb.DAT_I[2];
        end
        if (in_we) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (in_we) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (start_cmd) begin
                    state_d    = S_RUN;
                    rd_cnt_d   = '0;
                    core_inv_d = wb.DAT_I[1];
                end
            end
            S_RUN: begin
                core_en_d = 1'b1;
                rd_cnt_d  = rd_cnt_q + Log2N'(1);
                if (rd_cnt_q == Log2N'(N - 1)) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_frame_ready) begin
                    frame_done  = 1'b1;
                    state_d     = S_IDLE;
                    wr_ptr_d    = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w1c) done_d = 1'b0;
        if (frame_done) done_d = 1'b1;

        if (abort_cmd) begin
            state_d      = S_IDLE;
            wr_ptr_d     = '0;
            done_d       = 1'b0;
            frame_cnt_d  = frame_cnt_q;
            core_en_d    = 1'b0;
            core_clear_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            done_q       <= 1'b0;
            frame_cnt_q  <= '0;
            inv_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            core_inv_q   <= 1'b0;
            core_en_q    <= 1'b0;
            core_clear_q <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_q        <= '0;
            mem_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            done_q       <= done_d;
            frame_cnt_q  <= frame_cnt_d;
            inv_q        <= inv_d;
            irq_en_q     <= irq_en_d;
            core_inv_q   <= core_inv_d;
            core_en_q    <= core_en_d;
            core_clear_q <= core_clear_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            dat_q        <= dat_d;
            mem_sel_q    <= mem_sel_d;
        end
    end

    // Input buffer: the read issued in RUN cycle k lands with the k-th enable cycle.
    always_ff @(posedge CLK_I) begin
        if (in_we) inbuf_mem[wr_ptr_q[Log2N-1:0]] <= wb.DAT_I;
        if (state_q == S_RUN) inbuf_rd_q <= inbuf_mem[rd_cnt_q];
    end

    always_ff @(posedge CLK_I) begin
        if (busy && core_out_valid) outbuf_mem[core_index] <= core_xout;
        if (mem_rd_en) mem_rd_q <= outbuf_mem[mem_idx];
    end

    assign wb.ACK_O     = ack_q;
    assign wb.ERR_O     = err_q;
    assign wb.DAT_O     = mem_sel_q ? mem_rd_q : dat_q;
    assign IRQ_O        = done_q & irq_en_q;
    assign core_enable  = core_en_q;
    assign core_clear   = core_clear_q;
    assign core_inverse = core_inv_q;
    assign core_xin     = core_en_q ? inbuf_rd_q : '0;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_fft_wb_frame_ctrl.sv
// Self-checking bench for fft_wb_frame_ctrl with N=8: register-map vector table,
// directed frame corner cases and randomized frames against a behavioural model.
module tb_fft_wb_frame_ctrl;
    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam logic [31:0] A_CTRL = 32'd0;
    localparam logic [31:0] A_DATA = 32'd4;
    localparam logic [31:0] A_STAT = 32'd8;
    localparam logic [31:0] A_MEM  = 32'd12;

    logic             clk;
    logic             rst_n;
    logic             irq_o, core_enable, core_clear, core_inverse;
    logic [31:0]      core_xin;
    logic             core_out_valid;
    logic [LOG2N-1:0] core_index;
    logic [31:0]      core_xout;
    logic             core_frame_ready;
    logic [1:0]       dbg_state;

    fft_wb_frame_ctrl_if #(.WB_Width(32), .Adress_wordwidth(32)) wb_bus ();

    fft_wb_frame_ctrl #(.WB_Width(32), .Adress_wordwidth(32), .N(N), .Log2N(LOG2N)) dut (
        .CLK_I           (clk),
        .RST_I           (rst_n),
        .wb              (wb_bus),
        .IRQ_O           (irq_o),
        .core_enable     (core_enable),
        .core_clear      (core_clear),
        .core_inverse    (core_inverse),
        .core_xin        (core_xin),
        .core_out_valid  (core_out_valid),
        .core_index      (core_index),
        .core_xout       (core_xout),
        .core_frame_ready(core_frame_ready),
        .dbg_state       (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the controller's visible state
    int          m_wr_ptr;
    bit          m_done, m_busy, m_inv, m_irq_en;
    int          m_fcnt;
    logic [31:0] exp_xin [N];
    logic [31:0] exp_out [N];

    function automatic logic [31:0] m_status();
        return {m_fcnt[15:0], 13'd0, (m_wr_ptr == N), m_done, m_busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdat, output logic err);
        bit got = 0;
        wb_bus.CYC_I = 1'b1;
        wb_bus.STB_I = 1'b1;
        wb_bus.WE_I  = we;
        wb_bus.ADR_I = adr;
        wb_bus.DAT_I = dat;
        rdat = '0;
        err  = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_bus.ACK_O || wb_bus.ERR_O) begin
                got  = 1;
                rdat = wb_bus.DAT_O;
                err  = wb_bus.ERR_O;
            end
        end
        wb_bus.CYC_I = 1'b0;
        wb_bus.STB_I = 1'b0;
        wb_bus.WE_I  = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_timeout: no ACK/ERR for adr 0x%08h", adr);
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic exp_err,
                      input string name);
        logic [31:0] rd_v;
        logic e;
        wb_xfer(1'b1, adr, dat, rd_v, e);
        check({name, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] rd_v;
        logic e;
        wb_xfer(1'b0, adr, 32'd0, rd_v, e);
        check({name, "_err"}, {31'd0, e}, 32'd0);
        check(name, rd_v, exp);
    endtask

    task automatic load(input int n, input bit rnd);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = rnd ? $urandom : 32'h0001_0000 * (i + 1);
            if (m_wr_ptr < N && !m_busy) begin
                wr(A_DATA, v, 1'b0, "data_wr");
                exp_xin[m_wr_ptr] = v;
                m_wr_ptr++;
            end else begin
                wr(A_DATA, v, 1'b1, "data_wr_full");
            end
            if (rnd && $urandom_range(0, 3) == 0) rd(A_DATA, m_wr_ptr, "data_rd_ptr");
        end
    endtask

    task automatic start(input bit inv, input bit irq_en);
        wr(A_CTRL, {29'd0, irq_en, inv, 1'b1}, 1'b0, "start");
        m_inv = inv; m_irq_en = irq_en; m_busy = 1;
        check("core_inverse", {31'd0, core_inverse}, {31'd0, inv});
    endtask

    task automatic collect_enables();
        int cnt = 0;
        bit seen = 0, ended = 0;
        for (int i = 0; i < 60 && !ended; i++) begin
            @(posedge clk); #1;
            if (core_enable) begin
                seen = 1;
                if (cnt < N) check($sformatf("xin%0d", cnt), core_xin, exp_xin[cnt]);
                cnt++;
            end else if (seen) begin
                ended = 1;
            end
        end
        check("enable_cycles", cnt, N);
    endtask

    // Fake core: emits every bin once, in shuffled order when asked.
    task automatic emit_bins(input logic [31:0] key, input bit shuffle);
        int order [N];
        int j, t;
        for (int i = 0; i < N; i++) order[i] = i;
        if (shuffle) begin
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        for (int i = 0; i < N; i++) begin
            core_out_valid = 1'b1;
            core_index     = order[i][LOG2N-1:0];
            core_xout      = (exp_xin[order[i]] >> 16) ^ key;
            exp_out[order[i]] = core_xout;
            @(posedge clk); #1;
        end
        core_out_valid = 1'b0;
    endtask

    task automatic frame_ready_pulse();
        core_frame_ready = 1'b1;
        @(posedge clk); #1;
        core_frame_ready = 1'b0;
    endtask

    task automatic model_frame_done();
        m_done = 1; m_fcnt++; m_wr_ptr = 0; m_busy = 0;
    endtask

    task automatic model_abort(input logic [31:0] ctrl);
        m_wr_ptr = 0; m_done = 0; m_busy = 0;
        m_inv = ctrl[1]; m_irq_en = ctrl[2];
    endtask

    task automatic check_mem_all();
        for (int k = 0; k < N; k++) rd(A_MEM + 4 * k, exp_out[k], $sformatf("mem%0d", k));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        exp_err;
        logic        chk;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_v;
        logic        e;
        logic [31:0] key;
        bit          inv_r;

        rst_n = 1'b0;
        wb_bus.CYC_I = 0; wb_bus.STB_I = 0; wb_bus.WE_I = 0;
        wb_bus.ADR_I = 0; wb_bus.DAT_I = 0;
        core_out_valid = 0; core_index = 0; core_xout = 0; core_frame_ready = 0;
        m_wr_ptr = 0; m_done = 0; m_busy = 0; m_inv = 0; m_irq_en = 0; m_fcnt = 0;
        for (int k = 0; k < N; k++) begin exp_xin[k] = 0; exp_out[k] = 0; end

        repeat (3) @(posedge clk); #1;
        check("rst_ack", {31'd0, wb_bus.ACK_O}, 32'd0);
        check("rst_err", {31'd0, wb_bus.ERR_O}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_enable", {31'd0, core_enable}, 32'd0);
        check("rst_clear", {31'd0, core_clear}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Register map in IDLE
        vecs[0]  = '{1'b0, A_CTRL, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, A_CTRL, 32'h6, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, A_CTRL, 32'h0, 1'b0, 1'b1, 32'h6};
        vecs[3]  = '{1'b1, A_CTRL, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, A_CTRL, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, A_STAT, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, A_DATA, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 32'h2C, 32'h5, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h2C, 32'h0, 1'b1, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0};
        vecs[10] = '{1'b1, A_MEM, 32'h1, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, A_MEM + 28, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, A_CTRL, 32'h1, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{1'b1, A_STAT, 32'h2, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, A_STAT, 32'h0, 1'b0, 1'b1, 32'h0};
        for (int i = 0; i < 15; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, rd_v, e);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            if (vecs[i].chk) check($sformatf("vec%0d_dat", i), rd_v, vecs[i].exp_dat);
        end

        // Directed frame with inverse select
        load(N, 0);
        rd(A_DATA, N, "data_rd_full");
        rd(A_STAT, m_status(), "stat_load_full");
        start(1, 0);
        collect_enables();
        rd(A_STAT, m_status(), "stat_wait");
        wr(A_MEM, 32'h0, 1'b1, "mem_rd_busy");
        wb_xfer(1'b0, A_MEM, 32'h0, rd_v, e);
        check("mem_rd_busy_err", {31'd0, e}, 32'd1);
        emit_bins(32'h0, 0);
        frame_ready_pulse();
        model_frame_done();
        rd(A_STAT, m_status(), "stat_done");
        rd(A_MEM + 12, 32'd4, "mem_k3");
        rd(A_CTRL, 32'h2, "ctrl_inv_kept");
        check("irq_no_en", {31'd0, irq_o}, 32'd0);

        // Illegal START with a partial frame, then overflow
        wr(A_STAT, 32'h2, 1'b0, "w1c");
        m_done = 0;
        load(5, 0);
        wr(A_CTRL, 32'h1, 1'b1, "start_partial");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("enable_idle", {31'd0, core_enable}, 32'd0);
        end
        rd(A_STAT, m_status(), "stat_partial");
        load(3, 0);
        wr(A_DATA, 32'hDEAD_BEEF, 1'b1, "data_wr_9th");
        rd(A_DATA, N, "data_rd_after_9th");

        // IRQ with W1C coincident with frame completion: set wins
        start(0, 1);
        collect_enables();
        emit_bins($urandom, 1);
        wb_bus.CYC_I = 1; wb_bus.STB_I = 1; wb_bus.WE_I = 1;
        wb_bus.ADR_I = A_STAT; wb_bus.DAT_I = 32'h2;
        core_frame_ready = 1'b1;
        @(posedge clk); #1;
        check("w1c_coinc_ack", {31'd0, wb_bus.ACK_O}, 32'd1);
        wb_bus.CYC_I = 0; wb_bus.STB_I = 0; wb_bus.WE_I = 0;
        core_frame_ready = 1'b0;
        model_frame_done();
        check("irq_set", {31'd0, irq_o}, {31'd0, m_done & m_irq_en});
        rd(A_STAT, m_status(), "stat_coinc");
        check_mem_all();
        wr(A_STAT, 32'h2, 1'b0, "w1c_alone");
        m_done = 0;
        check("irq_cleared", {31'd0, irq_o}, 32'd0);

        // ABORT while waiting for the core
        load(N, 1);
        start(0, 0);
        collect_enables();
        wr(A_CTRL, 32'h8, 1'b0, "abort");
        model_abort(32'h8);
        check("clear_pulse", {31'd0, core_clear}, 32'd1);
        @(posedge clk); #1;
        check("clear_drop", {31'd0, core_clear}, 32'd0);
        rd(A_STAT, m_status(), "stat_abort");
        rd(A_DATA, 32'd0, "data_rd_abort");
        wb_xfer(1'b0, A_MEM + 4, 32'h0, rd_v, e);
        check("mem_rd_after_abort_err", {31'd0, e}, 32'd0);
        frame_ready_pulse();
        rd(A_STAT, m_status(), "stat_ready_ignored");

        // ABORT together with START
        load(N, 1);
        wr(A_CTRL, 32'h9, 1'b0, "abort_start");
        model_abort(32'h9);
        repeat (2) begin
            @(posedge clk); #1;
            check("enable_after_abort_start", {31'd0, core_enable}, 32'd0);
        end
        rd(A_STAT, m_status(), "stat_abort_start");

        // Randomized frames
        for (int f = 0; f < 4; f++) begin
            inv_r = 1'($urandom_range(0, 1));
            key   = $urandom;
            load(N, 1);
            start(inv_r, 1'($urandom_range(0, 1)));
            collect_enables();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            emit_bins(key, 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            frame_ready_pulse();
            model_frame_done();
            check($sformatf("irq_f%0d", f), {31'd0, irq_o}, {31'd0, m_done & m_irq_en});
            rd(A_STAT, m_status(), $sformatf("stat_f%0d", f));
            check_mem_all();
        end

        // Asynchronous reset in the middle of RUN
        wr(A_CTRL, 32'h4, 1'b0, "irq_en");
        m_irq_en = 1; m_inv = 0;
        check("irq_before_rst", {31'd0, irq_o}, {31'd0, m_done & m_irq_en});
        load(N, 1);
        start(0, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("enable_mid_run", {31'd0, core_enable}, 32'd1);
        wb_bus.CYC_I = 1; wb_bus.STB_I = 1; wb_bus.WE_I = 0; wb_bus.ADR_I = A_STAT;
        @(posedge clk); #1;
        check("ack_before_rst", {31'd0, wb_bus.ACK_O}, 32'd1);
        wb_bus.CYC_I = 0; wb_bus.STB_I = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_enable", {31'd0, core_enable}, 32'd0);
        check("rst_async_ack", {31'd0, wb_bus.ACK_O}, 32'd0);
        check("rst_async_irq", {31'd0, irq_o}, 32'd0);
        #4 rst_n = 1'b1;
        m_wr_ptr = 0; m_done = 0; m_busy = 0; m_inv = 0; m_irq_en = 0; m_fcnt = 0;
        @(posedge clk); #1;
        check("state_after_rst", {30'd0, dbg_state}, 32'd0);
        rd(A_STAT, m_status(), "stat_after_rst");
        rd(A_CTRL, 32'd0, "ctrl_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
